// File: rtl/fifo_pkt_reader.sv
// Parses length-prefixed packets from a show-ahead FIFO and forwards the payload on a valid/ready stream.
// Define FIFO_PKT_CNT_EN to add the 16-bit completed-packet counter output pkt_cnt.
module fifo_pkt_reader #(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready
`ifdef FIFO_PKT_CNT_EN
  ,
  output logic [15:0]      pkt_cnt
`endif
);

  typedef enum logic {
    ST_HDR = 1'b0,
    ST_PAY = 1'b1
  } state_t;

  state_t           r_state;
  logic [DSIZE-1:0] r_cnt;
  logic [DSIZE-1:0] r_m_data;
  logic             r_m_valid;
  logic             r_m_last;

  logic w_hdr_pop;
  logic w_pay_pop;
  logic w_hshk;
  logic w_cnt_one;

  // Pops are gated by rrst_n so the FIFO is never drained while reset is held.
  assign w_hdr_pop = rrst_n && (r_state == ST_HDR) && !rempty;
  assign w_pay_pop = rrst_n && (r_state == ST_PAY) && !rempty && (!r_m_valid || m_ready);
  assign w_hshk    = r_m_valid && m_ready;
  assign w_cnt_one = (r_cnt == DSIZE'(1));
  assign rinc      = w_hdr_pop | w_pay_pop;

  assign m_data  = r_m_data;
  assign m_valid = r_m_valid;
  assign m_last  = r_m_last;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state   <= ST_HDR;
      r_cnt     <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_HDR: begin
          if (w_hdr_pop) begin
            r_cnt <= rdata;
            if (rdata != '0) begin
              r_state <= ST_PAY;
            end
          end
        end
        ST_PAY: begin
          if (w_pay_pop) begin
            r_cnt <= r_cnt - DSIZE'(1);
            if (w_cnt_one) begin
              r_state <= ST_HDR;
            end
          end
        end
        default: r_state <= ST_HDR;
      endcase

      // The output register is independent of state: a header may be popped while the last word waits.
      if (w_pay_pop) begin
        r_m_data  <= rdata;
        r_m_valid <= 1'b1;
        r_m_last  <= w_cnt_one;
      end else if (w_hshk) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end
    end
  end

`ifdef FIFO_PKT_CNT_EN
  logic [15:0] r_pkt_cnt;
  logic        w_done_last;
  logic        w_done_zero;

  assign w_done_last = w_hshk && r_m_last;
  assign w_done_zero = w_hdr_pop && (rdata == '0);
  assign pkt_cnt     = r_pkt_cnt;

  // Both events can coincide (last word accepted while an empty packet's header is popped).
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_pkt_cnt <= '0;
    end else begin
      r_pkt_cnt <= r_pkt_cnt + {15'd0, w_done_last} + {15'd0, w_done_zero};
    end
  end
`endif

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed, table-driven bench for fifo_pkt_reader: each row drives one cycle and checks rinc and outputs.
// With FIFO_PKT_CNT_EN defined it also exercises the packet counter, including its 16-bit wrap.
module tb_fifo_pkt_reader;

  logic       rclk    = 1'b0;
  logic       rrst_n  = 1'b0;
  logic       rempty  = 1'b1;
  logic [7:0] rdata   = 8'h00;
  logic       m_ready = 1'b0;
  logic       rinc;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
`ifdef FIFO_PKT_CNT_EN
  logic [15:0] pkt_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int row_idx  = 0;

  always #5 rclk = ~rclk;

  fifo_pkt_reader #(.DSIZE(8)) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_last  (m_last),
    .m_ready (m_ready)
`ifdef FIFO_PKT_CNT_EN
    ,
    .pkt_cnt (pkt_cnt)
`endif
  );

  typedef struct {
    logic       rst_n;
    logic       emp;
    logic [7:0] d;
    logic       rdy;
    logic       e_rinc;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_last;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int rst, int emp, int d, int rdy, int er, int ev, int ed, int el);
    vec_t v;
    v.rst_n   = 1'(rst);
    v.emp     = 1'(emp);
    v.d       = 8'(d);
    v.rdy     = 1'(rdy);
    v.e_rinc  = 1'(er);
    v.e_valid = 1'(ev);
    v.e_data  = 8'(ed);
    v.e_last  = 1'(el);
    vecs.push_back(v);
  endfunction

  task automatic check(string name, int idx, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Inputs change on the falling edge; checks happen 1 time unit later, well before the next rising edge.
  task automatic apply(vec_t v);
    @(negedge rclk);
    rrst_n  = v.rst_n;
    rempty  = v.emp;
    rdata   = v.d;
    m_ready = v.rdy;
    #1;
    check("rinc", row_idx, 16'(rinc), 16'(v.e_rinc));
    check("m_valid", row_idx, 16'(m_valid), 16'(v.e_valid));
    if (v.e_valid || !v.rst_n) begin
      check("m_data", row_idx, 16'(m_data), 16'(v.e_data));
      check("m_last", row_idx, 16'(m_last), 16'(v.e_last));
    end
    if (m_valid && m_ready)
      $display("row %0d: word %h last=%b accepted", row_idx, m_data, m_last);
    row_idx++;
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) apply(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    // reset held with data present: no pop, outputs cleared
    add(0,0,8'h05,1, 0,0,8'h00,0);
    add(1,1,8'h00,1, 0,0,8'h00,0);

    // 03,A1,A2,A3 with m_ready=1
    add(1,0,8'h03,1, 1,0,8'h00,0);
    add(1,0,8'hA1,1, 1,0,8'h00,0);
    add(1,0,8'hA2,1, 1,1,8'hA1,0);
    add(1,0,8'hA3,1, 1,1,8'hA2,0);
    add(1,1,8'h00,1, 0,1,8'hA3,1);
    add(1,1,8'h00,1, 0,0,8'h00,0);

    // 02,B1,B2 with m_ready low for 5 cycles
    add(1,0,8'h02,0, 1,0,8'h00,0);
    add(1,0,8'hB1,0, 1,0,8'h00,0);
    for (int k = 0; k < 5; k++) add(1,0,8'hB2,0, 0,1,8'hB1,0);
    add(1,0,8'hB2,1, 1,1,8'hB1,0);
    add(1,1,8'h00,1, 0,1,8'hB2,1);
    add(1,1,8'h00,1, 0,0,8'h00,0);

    // 00,01,C1: empty packet then one word
    add(1,0,8'h00,1, 1,0,8'h00,0);
    add(1,0,8'h01,1, 1,0,8'h00,0);
    add(1,0,8'hC1,1, 1,0,8'h00,0);
    add(1,1,8'h00,1, 0,1,8'hC1,1);
    add(1,1,8'h00,1, 0,0,8'h00,0);

    // 04,D1..D4 with rempty toggling; m_ready low while idle is ignored
    add(1,0,8'h04,1, 1,0,8'h00,0);
    add(1,1,8'h00,0, 0,0,8'h00,0);
    add(1,0,8'hD1,1, 1,0,8'h00,0);
    add(1,1,8'h00,1, 0,1,8'hD1,0);
    add(1,0,8'hD2,1, 1,0,8'h00,0);
    add(1,1,8'h00,1, 0,1,8'hD2,0);
    add(1,0,8'hD3,1, 1,0,8'h00,0);
    add(1,1,8'h00,1, 0,1,8'hD3,0);
    add(1,0,8'hD4,1, 1,0,8'h00,0);
    add(1,1,8'h00,1, 0,1,8'hD4,1);
    add(1,1,8'h00,1, 0,0,8'h00,0);

    // next header popped while the previous last word is still held
    add(1,0,8'h01,0, 1,0,8'h00,0);
    add(1,0,8'hE1,0, 1,0,8'h00,0);
    add(1,0,8'h01,0, 1,1,8'hE1,1);
    add(1,0,8'hE2,0, 0,1,8'hE1,1);
    add(1,0,8'hE2,1, 1,1,8'hE1,1);
    add(1,1,8'h00,1, 0,1,8'hE2,1);
    add(1,1,8'h00,1, 0,0,8'h00,0);

    // reset after 2 of 5 payload words, then refilled FIFO starts with a header
    add(1,0,8'h05,1, 1,0,8'h00,0);
    add(1,0,8'hF1,1, 1,0,8'h00,0);
    add(1,0,8'hF2,1, 1,1,8'hF1,0);
    add(0,0,8'hF3,1, 0,0,8'h00,0);
    add(1,0,8'h01,1, 1,0,8'h00,0);
    add(1,0,8'h71,1, 1,0,8'h00,0);
    add(1,1,8'h00,1, 0,1,8'h71,1);
    add(1,1,8'h00,1, 0,0,8'h00,0);

    // maximum length 255: counter must not wrap
    add(1,0,8'hFF,1, 1,0,8'h00,0);
    for (int k = 1; k <= 255; k++) add(1,0,k,1, 1,(k > 1),k-1,0);
    add(1,1,8'h00,1, 0,1,8'hFF,1);
    add(1,1,8'h00,1, 0,0,8'h00,0);

    run_vecs();

`ifdef FIFO_PKT_CNT_EN
    add(0,1,8'h00,1, 0,0,8'h00,0);
    run_vecs();
    check("pkt_cnt_reset", row_idx, pkt_cnt, 16'd0);

    add(1,0,8'h00,1, 1,0,8'h00,0);
    add(1,0,8'h01,1, 1,0,8'h00,0);
    add(1,0,8'hC1,1, 1,0,8'h00,0);
    add(1,1,8'h00,1, 0,1,8'hC1,1);
    add(1,1,8'h00,1, 0,0,8'h00,0);
    run_vecs();
    check("pkt_cnt_two", row_idx, pkt_cnt, 16'd2);

    add(0,1,8'h00,1, 0,0,8'h00,0);
    run_vecs();
    for (int k = 0; k < 65537; k++) begin
      add(1,0,8'h00,1, 1,0,8'h00,0);
      run_vecs();
    end
    add(1,1,8'h00,1, 0,0,8'h00,0);
    run_vecs();
    check("pkt_cnt_wrap", row_idx, pkt_cnt, 16'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_pkt_reader.md
FIFO_PKT_READER -- requirements
Module: fifo_pkt_reader

Interface
REQ-001 SHALL have parameter DSIZE, default 8, meaning width of FIFO read data, output data and packet header.
REQ-002 SHALL have port rclk  input  1  read-domain clock; all state changes on its rising edge.
REQ-003 SHALL have port rrst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rempty  input  1  FIFO read side empty; rdata valid whenever low (show-ahead).
REQ-005 SHALL have port rdata  input  DSIZE  FIFO word at current read address.
REQ-006 SHALL have port rinc  output  1  pop strobe to FIFO; one word consumed per cycle high.
REQ-007 SHALL have port m_data  output  DSIZE  payload word to consumer.
REQ-008 SHALL have port m_valid  output  1  m_data/m_last valid.
REQ-009 SHALL have port m_last  output  1  final payload word of current packet.
REQ-010 SHALL have port m_ready  input  1  consumer accepts word when high with m_valid.
REQ-011 SHALL have port pkt_cnt  output  16  completed-packet count; present only under FIFO_PKT_CNT_EN.

Function
REQ-012 SHALL parse FIFO stream as packets: one header word holding length L (0..2^DSIZE-1, unsigned), then exactly L payload words.
REQ-013 SHALL implement states HDR (await header) and PAY (forward payload); reset state HDR.
REQ-014 SHALL, in HDR with rempty=0, assert rinc, load remaining count with L; next state PAY if L!=0, else HDR.
REQ-015 SHALL, in PAY, assert rinc iff rempty=0 and (m_valid=0 or m_ready=1); rinc combinational from these inputs and state.
REQ-016 SHALL never assert rinc while rempty=1.
REQ-017 SHALL register a popped payload word onto m_data with m_valid=1 in the following cycle (latency 1); sustained throughput 1 word/cycle with m_ready=1 and FIFO non-empty.
REQ-018 SHALL decrement remaining count per payload pop; m_last=1 on the word popped when count=1; state returns to HDR after that pop.
REQ-019 SHALL hold m_data, m_last, m_valid stable while m_valid=1 and m_ready=0.
REQ-020 SHALL clear m_valid after handshake (m_valid&m_ready) when no new word popped that cycle.
REQ-021 SHALL allow header pop of next packet in the cycle after the last payload pop, without waiting for the last word's handshake, while m_valid is held.
REQ-022 SHALL produce no m_valid for L=0 packets; header alone consumed.
REQ-023 SHALL handle count width DSIZE; L=2^DSIZE-1 forwards 2^DSIZE-1 words with no wrap.
REQ-024 SHALL treat m_ready as don't-care while m_valid=0.

Reset
REQ-025 SHALL on rrst_n low immediately: state HDR, count 0, m_valid 0, m_last 0, m_data 0, pkt_cnt 0; rinc 0 while reset asserted.
REQ-026 SHALL abandon any partial packet on reset mid-packet; first word after reset release treated as header (FIFO read side shares rrst_n).
REQ-027 SHALL leave reset on first rclk edge after rrst_n deassertion; no extra idle cycles.

Configuration
REQ-028 SHALL, with macro FIFO_PKT_CNT_EN defined, provide pkt_cnt: +1 on handshake of m_last word and +1 on consumption of an L=0 header; wraps 16'hFFFF->0.
REQ-029 SHALL, without FIFO_PKT_CNT_EN, omit pkt_cnt port and counter logic; all other behaviour identical.

Verification
REQ-030 SHALL cover: FIFO holds 03,A1,A2,A3, m_ready=1 -> A1,A2,A3 on consecutive cycles, m_last only with A3, rinc high 4 consecutive cycles.
REQ-031 SHALL cover: packet 02,B1,B2 with m_ready=0 for 5 cycles -> B1 held stable, B2 not popped, rinc low until m_ready=1.
REQ-032 SHALL cover: stream 00,01,C1 -> no output for first packet, C1 with m_last=1; pkt_cnt=2 when FIFO_PKT_CNT_EN defined.
REQ-033 SHALL cover: rempty toggling every cycle during 04,D1..D4 -> rinc never high with rempty=1, D1..D4 delivered in order, m_last on D4.
REQ-034 SHALL cover: rrst_n pulsed low after 2 of 5 payload words -> m_valid=0 immediately, state HDR, next word after FIFO refill parsed as header.
REQ-035 SHALL cover: 65537 L=0 headers with FIFO_PKT_CNT_EN -> pkt_cnt=1 (wrap).
